// File: rtl/led_fade_ctrl_pkg.sv
// Shared definitions for the LED fade controller: channel FSM states,
// default intensity width and a counter-sizing helper.
package led_fade_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int NUM_CHAN      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UP     = 3'd1,
    ST_HOLD_H = 3'd2,
    ST_DOWN   = 3'd3,
    ST_HOLD_L = 3'd4
  } state_t;

  // Bits needed to hold every value in 0..maxVal (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One breathing channel: switch synchroniser, ramp/hold sequencer, shadowed
// intensity register and the registered PWM compare driving the LED.
module led_fade_channel
  import led_fade_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MAX_INTENS = 4094,
  parameter int MIN_INTENS = 0,
  parameter int HOLD_STEPS = 512
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_sw,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_pwmCnt,
  input  logic             i_periodEnd,
  output logic             o_led,
  output logic [WIDTH-1:0] o_intens,
  output logic             o_active
);

  localparam int HW = cntWidth(HOLD_STEPS);

  localparam logic [WIDTH-1:0] MAX_LVL   = WIDTH'(MAX_INTENS);
  localparam logic [WIDTH-1:0] MAX_M1    = WIDTH'(MAX_INTENS - 1);
  localparam logic [WIDTH-1:0] MIN_LVL   = WIDTH'(MIN_INTENS);
  localparam logic [WIDTH-1:0] LVL_ONE   = WIDTH'(1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);

  logic             r_sync0;
  logic             r_sync1;
  logic             w_swq;
  state_t           r_state;
  state_t           w_stateNxt;
  logic [WIDTH-1:0] r_lvl;
  logic [WIDTH-1:0] w_lvlNxt;
  logic [WIDTH-1:0] w_floor;
  logic [HW-1:0]    r_holdCnt;
  logic [HW-1:0]    w_holdNxt;
  logic [WIDTH-1:0] r_intens;
  logic             r_led;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_sw;
      r_sync1 <= r_sync0;
    end
  end

  assign w_swq   = r_sync1;
  // A released switch fades all the way to 0; a held one breathes down to MIN.
  assign w_floor = w_swq ? MIN_LVL : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_swq) begin
            w_stateNxt = ST_UP;
          end
        end
        ST_UP: begin
          if (!w_swq) begin
            w_stateNxt = ST_DOWN;
          end else if (r_lvl >= MAX_M1) begin
            w_stateNxt = ST_HOLD_H;
          end
        end
        ST_HOLD_H: begin
          if (!w_swq || (r_holdCnt == HOLD_LAST)) begin
            w_stateNxt = ST_DOWN;
          end
        end
        ST_DOWN: begin
          // No reversal mid-ramp: the switch only picks the floor and exit.
          if (r_lvl <= w_floor) begin
            w_stateNxt = w_swq ? ST_HOLD_L : ST_IDLE;
          end
        end
        ST_HOLD_L: begin
          if (!w_swq) begin
            w_stateNxt = ST_DOWN;
          end else if (r_holdCnt == HOLD_LAST) begin
            w_stateNxt = ST_UP;
          end
        end
        default: w_stateNxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_lvlNxt  = r_lvl;
    w_holdNxt = r_holdCnt;
    if (i_tick) begin
      case (r_state)
        ST_IDLE: w_lvlNxt = '0;
        ST_UP: begin
          if (w_swq) begin
            if (r_lvl >= MAX_M1) begin
              w_lvlNxt  = MAX_LVL;
              w_holdNxt = '0;
            end else begin
              w_lvlNxt = r_lvl + LVL_ONE;
            end
          end
        end
        ST_HOLD_H, ST_HOLD_L: begin
          if (w_swq) begin
            w_holdNxt = r_holdCnt + HOLD_ONE;
          end
        end
        ST_DOWN: begin
          if (r_lvl > w_floor) begin
            w_lvlNxt = r_lvl - LVL_ONE;
          end else if (w_swq) begin
            w_holdNxt = '0;
          end
        end
        default: begin
          w_lvlNxt  = '0;
          w_holdNxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lvl     <= '0;
      r_holdCnt <= '0;
    end else begin
      r_lvl     <= w_lvlNxt;
      r_holdCnt <= w_holdNxt;
    end
  end

  // Intensity only changes on the last count of a PWM period, so a period
  // is never split between two duty values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_intens <= '0;
      r_led    <= 1'b0;
    end else begin
      if (i_periodEnd) begin
        r_intens <= r_lvl;
      end
      r_led <= (i_pwmCnt < r_intens);
    end
  end

  assign o_led    = r_led;
  assign o_intens = r_intens;
  assign o_active = (r_state != ST_IDLE) || (r_intens != '0);

endmodule

// File: rtl/led_fade_ctrl.sv
// Four-channel LED breathing controller: shared step prescaler and PWM
// counter feeding four independent fade channels.
module led_fade_ctrl
  import led_fade_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int STEP_DIV   = 24414,
  parameter int MAX_INTENS = 4094,
  parameter int MIN_INTENS = 0,
  parameter int HOLD_STEPS = 512
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CHAN-1:0]       sw,
  output logic [NUM_CHAN-1:0]       led,
  output logic [NUM_CHAN*WIDTH-1:0] intens,
  output logic                      busy
);

  localparam int PW = cntWidth(STEP_DIV - 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] PWM_ONE    = WIDTH'(1);

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [WIDTH-1:0]    r_pwmCnt;
  logic                w_periodEnd;
  logic [NUM_CHAN-1:0] w_active;
  logic                r_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwmCnt <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + PWM_ONE;
    end
  end

  assign w_periodEnd = &r_pwmCnt;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    led_fade_channel #(
      .WIDTH      (WIDTH),
      .MAX_INTENS (MAX_INTENS),
      .MIN_INTENS (MIN_INTENS),
      .HOLD_STEPS (HOLD_STEPS)
    ) u_chan (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_sw        (sw[g]),
      .i_tick      (w_tick),
      .i_pwmCnt    (r_pwmCnt),
      .i_periodEnd (w_periodEnd),
      .o_led       (led[g]),
      .o_intens    (intens[g*WIDTH +: WIDTH]),
      .o_active    (w_active[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_active;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl with small parameters (WIDTH=4,
// STEP_DIV=4, MAX=8, MIN=2, HOLD=2); expected values are worked out per edge.
module tb_led_fade_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [3:0]     sw;
  logic [3:0]     led;
  logic [4*W-1:0] intens;
  logic           busy;

  int checkCount = 0;
  int failCount  = 0;
  int edgeCnt    = 0;
  int xCount     = 0;

  led_fade_ctrl #(
    .WIDTH      (W),
    .STEP_DIV   (4),
    .MAX_INTENS (8),
    .MIN_INTENS (2),
    .HOLD_STEPS (2)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw     (sw),
    .led    (led),
    .intens (intens),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn === 1'b1 && $isunknown({led, intens, busy})) begin
      xCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after rising edge k (edge 1 is the first after reset release).
  task automatic runTo(input int k);
    while (edgeCnt < k) begin
      @(posedge clk);
      edgeCnt++;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] swVal);
    sw = swVal;
  endtask

  task automatic resetDut(input logic [3:0] swVal);
    rstn = 1'b0;
    applyStimulus(swVal);
    repeat (3) @(posedge clk);
    #1;
    rstn    = 1'b1;
    edgeCnt = 0;
  endtask

  function automatic logic [W-1:0] chan(input int i);
    return intens[i*W +: W];
  endfunction

  initial begin
    int bad;
    int hi;

    rstn = 1'b0;
    sw   = 4'h0;
    #1;
    checkOutput("rst_led", {28'h0, led}, 32'h0);
    checkOutput("rst_intens", {16'h0, intens}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);

    resetDut(4'h0);
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      runTo(k);
      if (led != 4'h0 || intens != 16'h0 || busy != 1'b0) bad++;
    end
    checkOutput("s1_quiet_cycles", bad, 0);

    // Channel 0 breathing cycle.
    resetDut(4'b0001);
    runTo(4);   checkOutput("s2_busy_e4", {31'h0, busy}, 0);
    runTo(5);   checkOutput("s2_busy_e5", {31'h0, busy}, 1);
    runTo(15);  checkOutput("s2_int_e15", chan(0), 0);
    runTo(16);  checkOutput("s2_int_e16", chan(0), 2);
    runTo(31);  checkOutput("s2_int_e31", chan(0), 2);
    runTo(32);  checkOutput("s2_int_e32", chan(0), 6);
    checkOutput("s2_others_e32", {20'h0, intens[15:4]}, 0);
    hi = 0;
    for (int k = 33; k <= 48; k++) begin
      runTo(k);
      if (led[0]) hi++;
    end
    checkOutput("s2_duty6", hi, 6);
    checkOutput("s2_int_e48", chan(0), 8);
    runTo(64);  checkOutput("s2_int_e64", chan(0), 4);
    runTo(80);  checkOutput("s2_int_e80", chan(0), 2);
    hi = 0;
    for (int k = 81; k <= 96; k++) begin
      runTo(k);
      if (led[0]) hi++;
    end
    checkOutput("s2_duty2", hi, 2);
    checkOutput("s2_int_e96", chan(0), 5);
    runTo(112); checkOutput("s2_int_e112", chan(0), 8);
    runTo(128); checkOutput("s2_int_e128", chan(0), 5);
    runTo(130); checkOutput("s2_led_e130", {31'h0, led[0]}, 1);
    rstn = 1'b0;
    #1;
    checkOutput("s1_midrst_led", {28'h0, led}, 0);
    checkOutput("s1_midrst_intens", {16'h0, intens}, 0);
    checkOutput("s1_midrst_busy", {31'h0, busy}, 0);

    // Channel 1 released during the up-ramp at lvl 5.
    resetDut(4'b0010);
    runTo(24);  applyStimulus(4'b0000);
    runTo(32);  checkOutput("s3_int_e32", chan(1), 5);
    runTo(48);  checkOutput("s3_int_e48", chan(1), 1);
    runTo(64);  checkOutput("s3_int_e64", chan(1), 0);
    checkOutput("s3_busy_e64", {31'h0, busy}, 1);
    runTo(65);  checkOutput("s3_busy_e65", {31'h0, busy}, 0);

    // Channel 2 released at lvl 4 on the way down, re-pressed at lvl 1.
    resetDut(4'b0100);
    runTo(48);  checkOutput("s4_int_e48", chan(2), 8);
    runTo(60);  applyStimulus(4'b0000);
    runTo(64);  checkOutput("s4_int_e64", chan(2), 4);
    runTo(72);  applyStimulus(4'b0100);
    runTo(80);  checkOutput("s4_int_e80", chan(2), 1);
    runTo(96);  checkOutput("s4_int_e96", chan(2), 3);

    // All channels together.
    resetDut(4'hF);
    runTo(10);  checkOutput("s5_busy", {31'h0, busy}, 1);
    runTo(32);  checkOutput("s5_int_e32", {16'h0, intens}, 32'h6666);
    runTo(33);  checkOutput("s5_led_e33", {28'h0, led}, 32'hF);
    runTo(38);  checkOutput("s5_led_e38", {28'h0, led}, 32'hF);
    runTo(39);  checkOutput("s5_led_e39", {28'h0, led}, 32'h0);
    runTo(48);  checkOutput("s5_int_e48", {16'h0, intens}, 32'h8888);

    // One-cycle glitch on sw[3] lined up with a tick.
    resetDut(4'h0);
    runTo(9);   applyStimulus(4'b1000);
    runTo(10);  applyStimulus(4'b0000);
    bad = 0;
    for (int k = 11; k <= 80; k++) begin
      runTo(k);
      if (intens != 16'h0) bad++;
      if (k == 13) checkOutput("s6_busy_e13", {31'h0, busy}, 1);
      if (k == 21) checkOutput("s6_busy_e21", {31'h0, busy}, 0);
    end
    checkOutput("s6_intens_zero", bad, 0);

    checkOutput("no_x", xCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/led_fade_ctrl.md
Name: led_fade_ctrl

Overview:
Four-channel breathing/fade controller for the Arty-A7 user LEDs. It replaces fixed per-LED intensity settings with a time-varying intensity per channel: ramp up, hold, ramp down, hold, repeat, for as long as that channel's switch is on. It contains one shared PWM counter and four per-channel fade sequencers. Each LED output is a PWM compare of the shared counter against that channel's current intensity.

Parameters:
WIDTH, 12, intensity and PWM counter width in bits (PWM period is 2^WIDTH cycles).
STEP_DIV, 24414, clk cycles per intensity step tick (about 1 s full ramp at 100 MHz, WIDTH=12).
MAX_INTENS, 4094, ramp-up ceiling; must be <= 2^WIDTH-1.
MIN_INTENS, 0, ramp-down floor while breathing; must be < MAX_INTENS.
HOLD_STEPS, 512, step ticks spent in each hold state.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
sw  in  4  per-channel enable, asynchronous to clk (board switches)
led  out  4  PWM LED drive, bit i drives channel i
intens  out  4*WIDTH  applied intensity, channel i in bits [i*WIDTH +: WIDTH]
busy  out  1  high when any channel is not in IDLE

Behaviour:
- Reset (rstn=0, async): all outputs 0; prescaler, PWM counter, hold counters 0; all channels IDLE; sync flops 0.
- sw synchronised with 2 flops per bit; all logic below uses the synchronised value swq.
- Prescaler: free-running 0..STEP_DIV-1. tick is a one-cycle pulse when it wraps. First tick occurs STEP_DIV cycles after reset release.
- PWM counter: free-running 0..2^WIDTH-1, natural wrap. led[i] = (pwm_cnt < intens_i), registered, so 1 cycle latency. intens=0 gives constantly off. Max duty is (2^WIDTH-1)/2^WIDTH.
- Shadow rule: each sequencer updates a working level lvl_i. intens_i loads lvl_i only in the cycle pwm_cnt == 2^WIDTH-1, so the change takes effect at the start of the next period and there are no mid-period glitches.
- Per-channel FSM. States: IDLE, UP, HOLD_H, DOWN, HOLD_L. Transitions are evaluated only on tick, except where marked.
  IDLE: lvl=0. swq=1 -> UP.
  UP: lvl+=1. When lvl reaches MAX_INTENS -> HOLD_H and clear the hold counter.
  HOLD_H: hold_cnt+=1. At HOLD_STEPS -> DOWN.
  DOWN: lvl-=1 while lvl > floor. floor = MIN_INTENS if swq=1, else 0. At lvl == floor: swq=1 -> HOLD_L; swq=0 -> IDLE.
  HOLD_L: hold_cnt+=1. At HOLD_STEPS -> UP.
- swq=0 in UP, HOLD_H or HOLD_L -> DOWN on the next tick (graceful fade-out to 0), starting from the current lvl. Must not underflow.
- swq returning to 1 during a fade-out DOWN: continue DOWN to MIN_INTENS, then HOLD_L. The channel must not reverse mid-ramp.
- lvl arithmetic is saturating. It never exceeds MAX_INTENS and never goes below 0, even if MIN_INTENS=0 and MAX_INTENS=2^WIDTH-1.
- busy is a registered OR of (state != IDLE) across channels, plus any intens_i != 0.
- Channels are independent and share only tick and pwm_cnt. Simultaneous events on different channels need no arbitration.
- Reset mid-operation: immediate return to reset state, with LEDs off within the same cycle (async clear of led flops).

Decomposition:
- Shared include led_fade_defs.vh holds the state encodings (3-bit localparams ST_IDLE..ST_HOLD_L) and the WIDTH default.
- One sub-module, led_fade_channel: sync flops, FSM, lvl, hold counter, shadow intens register and led compare flop. Inputs are tick, pwm_cnt and the period-end strobe.
- The top instantiates the prescaler, the PWM counter and 4 channels via generate.

Test Plan:
All scenarios use WIDTH=4, STEP_DIV=4, MAX_INTENS=8, MIN_INTENS=2, HOLD_STEPS=2.
1. Reset, sw=0 for 200 cycles -> led=0, intens=0, busy=0 throughout; a mid-run rstn pulse clears led in the same cycle.
2. sw[0]=1 held -> intens_0 climbs 1..8 with one step per tick, applied only at pwm_cnt=15 boundaries; holds at 8 for 2 ticks; falls to 2; holds 2 ticks; climbs again. led0 high exactly intens_0 of every 16 cycles.
3. sw[1] rises, then falls once intens_1=5 during UP -> next tick enters DOWN, lvl goes 5,4..0, then IDLE, and busy drops after intens_1=0 is applied.
4. sw[2] falls during DOWN at lvl=4 and rises again at lvl=1 -> lvl reaches 0? No: it stops at MIN_INTENS=2 only if swq=1 at the floor check. Verify lvl=1 -> floor re-evaluated at 2 -> lvl stays >=... bench checks that no underflow occurs, the channel ends in HOLD_L at floor 2 or below, then goes to UP.
5. All four sw toggled on the same cycle -> four identical waveforms, identical led patterns, busy=1.
6. sw glitch of 1 clk (shorter than the synchroniser window) -> at most one extra tick of effect; no X, no intens above 8.
